global_mem_bank_arbiter: RTL

- Shares one global-memory SRAM bank among N_REQ requesters (PE load/store ports plus the periphery port) with round-robin arbitration.
- Issues at most one access per cycle to the bank.
- Routes read data back to the granted requester after the bank read latency.
- One instance per bank; it sits between the interconnect request fan-in and the bank macro.

---
 rtl/global_mem_bank_arbiter_pkg.sv | 16 +
 rtl/global_mem_bank_arbiter_rr_arbiter.sv | 54 +++++
 rtl/global_mem_bank_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/global_mem_bank_arbiter_pkg.sv
// Shared constants and types for the global-memory bank arbiter slice.
// ARB_N_REQ sets the default arbitration width. The bank address and data
// widths and the bank read latency describe one global-memory SRAM bank.
// RESET_STATE is the asserted level of the active-low synchronous reset.
package global_mem_bank_arbiter_pkg;

    localparam int GLOBAL_MEM_PER_BANK_ADDR_L = 16;
    localparam int HW_DATA_L                  = 32;
    localparam int GLOBAL_MEM_RD_LATENCY      = 1;
    localparam int ARB_N_REQ                  = 4;
    localparam logic RESET_STATE              = 1'b0;

    typedef logic [GLOBAL_MEM_PER_BANK_ADDR_L-1:0] gm_bank_addr_t;
    typedef logic [HW_DATA_L-1:0]                  gm_data_t;

endpackage

// File: rtl/global_mem_bank_arbiter_rr_arbiter.sv
// Round-robin arbiter shared by the global-memory and stream-memory arbiters.
// The search starts at ptr and runs upward modulo N. After a grant to index g,
// ptr moves to g+1 so that g has the lowest priority on the next cycle.
// N must be a power of two (at least 2): the pointer then wraps naturally.
// Ports:
//   clk  in  1  clock
//   rst  in  1  synchronous reset, active low
//   req  in  N  request vector
//   gnt  out N  one-hot-or-zero grant, combinational; forced to zero in reset
module rr_arbiter
    import global_mem_bank_arbiter_pkg::*;
#(
    parameter int N = ARB_N_REQ
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx;
    logic [PTR_W-1:0] gnt_idx;
    logic             found;

    // Rotating priority search. idx wraps for free because N is a power of two.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        if (rst != RESET_STATE) begin
            for (int k = 0; k < N; k++) begin
                idx = ptr + PTR_W'(k);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    gnt_idx  = idx;
                    found    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RESET_STATE) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= gnt_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/global_mem_bank_arbiter.sv
// Shares one global-memory SRAM bank among N_REQ requesters. Arbitration is
// round-robin, with at most one bank access per cycle. Read data goes back to
// the granted requester RD_LATENCY cycles after the grant.
// Ports:
//   clk          in   1             clock
//   rst          in   1             synchronous reset, active low
//   req_rd_en    in   N_REQ         per-requester read request
//   req_wr_en    in   N_REQ         per-requester write request
//   req_addr     in   N_REQ*ADDR_L  packed addresses, requester i at [i*ADDR_L +: ADDR_L]
//   req_wr_data  in   N_REQ*DATA_L  packed write data, same packing
//   gnt          out  N_REQ         one-hot-or-zero grant, same cycle as the request
//   rsp_vld      out  N_REQ         read data valid per requester
//   rsp_data     out  DATA_L        read data broadcast, qualified by rsp_vld
//   mem_en       out  1             bank enable
//   mem_we       out  1             bank write enable
//   mem_addr     out  ADDR_L        bank address
//   mem_wr_data  out  DATA_L        bank write data
//   mem_rd_data  in   DATA_L        bank read data, RD_LATENCY cycles after a read
module global_mem_bank_arbiter
    import global_mem_bank_arbiter_pkg::*;
#(
    parameter int N_REQ      = ARB_N_REQ,
    parameter int ADDR_L     = GLOBAL_MEM_PER_BANK_ADDR_L,
    parameter int DATA_L     = HW_DATA_L,
    parameter int RD_LATENCY = GLOBAL_MEM_RD_LATENCY
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_rd_en,
    input  logic [N_REQ-1:0]         req_wr_en,
    input  logic [N_REQ*ADDR_L-1:0]  req_addr,
    input  logic [N_REQ*DATA_L-1:0]  req_wr_data,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         rsp_vld,
    output logic [DATA_L-1:0]        rsp_data,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [ADDR_L-1:0]        mem_addr,
    output logic [DATA_L-1:0]        mem_wr_data,
    input  logic [DATA_L-1:0]        mem_rd_data
);

    logic [N_REQ-1:0] req;

    assign req = req_rd_en | req_wr_en;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    // Bank drive muxed by the one-hot grant. A requester raising rd and wr
    // together is treated as a write, so it never produces a read response.
    always_comb begin
        mem_en      = |gnt;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                mem_we      = req_wr_en[i];
                mem_addr    = req_addr[i*ADDR_L +: ADDR_L];
                mem_wr_data = req_wr_data[i*DATA_L +: DATA_L];
            end
        end
    end

    // Response tag pipeline: stage 0 captures a read grant, the last stage
    // lines up with mem_rd_data. Reset drops every in-flight response.
    logic             vld_p [RD_LATENCY];
    logic [N_REQ-1:0] tag_p [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (rst == RESET_STATE) begin
            for (int s = 0; s < RD_LATENCY; s++) begin
                vld_p[s] <= 1'b0;
                tag_p[s] <= '0;
            end
        end else begin
            vld_p[0] <= mem_en & ~mem_we;
            tag_p[0] <= gnt;
            for (int s = 1; s < RD_LATENCY; s++) begin
                vld_p[s] <= vld_p[s-1];
                tag_p[s] <= tag_p[s-1];
            end
        end
    end

    assign rsp_vld  = vld_p[RD_LATENCY-1] ? tag_p[RD_LATENCY-1] : '0;
    assign rsp_data = mem_rd_data;

endmodule
